// File: rtl/cpu_defs.sv
// cpu_defs: shared execute-stage definitions for the MIPS core.
// This file holds the divider state encoding and the alucontrol codes that request a divide.
package cpu_defs;
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_ZERO = 2'd1,
      DIV_ON   = 2'd2,
      DIV_END  = 2'd3
   } div_state_e;

   localparam logic [3:0] ALU_DIV  = 4'b1000;
   localparam logic [3:0] ALU_DIVU = 4'b1001;

   // The execute stage decodes start_i and signed_i with these two helpers.
   function automatic logic is_div(input logic [3:0] alucontrol);
      return (alucontrol == ALU_DIV) || (alucontrol == ALU_DIVU);
   endfunction

   function automatic logic is_signed_div(input logic [3:0] alucontrol);
      return alucontrol == ALU_DIV;
   endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration.
// It shifts {rem, dvd} left by one, then trial-subtracts the divisor.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] dvd_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH:0]   rem_o,
   output logic [WIDTH-1:0] dvd_o
);
   // One extra bit beyond the remainder keeps the trial sign unambiguous.
   logic [WIDTH+1:0] sh, diff;
   assign sh    = {rem_i, dvd_i[WIDTH-1]};
   assign diff  = sh - {2'b00, dvs_i};
   assign rem_o = diff[WIDTH+1] ? sh[WIDTH:0] : diff[WIDTH:0];
   assign dvd_o = {dvd_i[WIDTH-2:0], ~diff[WIDTH+1]};
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for the execute stage.
// The result {remainder, quotient} feeds the HI/LO write, and stall_o holds the pipeline.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic               annul_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               stall_o
);
   import cpu_defs::*;

   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH:0]     rem_q, rem_d, rem_n;
   logic [WIDTH-1:0]   dvd_q, dvd_d, dvd_n, dvs_q, dvs_d;
   logic               qneg_q, qneg_d, rneg_q, rneg_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               ready_q, ready_d;
   logic               s1, s2;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i(rem_q),
      .dvd_i(dvd_q),
      .dvs_i(dvs_q),
      .rem_o(rem_n),
      .dvd_o(dvd_n)
   );

   assign s1      = signed_i & opdata1_i[WIDTH-1];
   assign s2      = signed_i & opdata2_i[WIDTH-1];
   assign quo_fix = qneg_q ? -dvd_n : dvd_n;
   assign rem_fix = rneg_q ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      ready_d  = ready_q;
      if (annul_i) begin
         state_d  = DIV_IDLE;
         ready_d  = 1'b0;
         result_d = '0;
      end else begin
         case (state_q)
            DIV_IDLE: begin
               ready_d  = 1'b0;
               result_d = '0;
               if (start_i && opdata2_i == '0) begin
                  state_d = DIV_ZERO;
               end else if (start_i) begin
                  // Magnitudes are divided unsigned; the signs are reapplied when the result is written.
                  state_d = DIV_ON;
                  cnt_d   = '0;
                  rem_d   = '0;
                  dvd_d   = s1 ? -opdata1_i : opdata1_i;
                  dvs_d   = s2 ? -opdata2_i : opdata2_i;
                  qneg_d  = s1 ^ s2;
                  rneg_d  = s1;
               end
            end
            DIV_ZERO: begin
               state_d  = DIV_END;
               ready_d  = 1'b1;
               result_d = '0;
            end
            DIV_ON: begin
               rem_d = rem_n;
               dvd_d = dvd_n;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d  = DIV_END;
                  ready_d  = 1'b1;
                  result_d = {rem_fix, quo_fix};
               end
            end
            default: begin
               if (!start_i) begin
                  state_d  = DIV_IDLE;
                  ready_d  = 1'b0;
                  result_d = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= DIV_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;
   assign stall_o  = start_i & ~ready_q;
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the execute stage of the 5-stage MIPS core.
- Sits directly downstream of the decode/execute control registers: the execute stage raises start_i when alucontrolE decodes DIV or DIVU.
- Holds the pipeline via stall_o to the hazard unit, and returns {remainder, quotient} for the HI/LO write (hilo_writeE path).

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- start_i  in  1  divide request; held high by the execute stage until ready_o is seen.
- signed_i  in  1  1=DIV (two's complement), 0=DIVU; sampled only in IDLE when start_i is accepted.
- annul_i  in  1  cancel: flushE or an exception flush of the instruction.
- opdata1_i  in  WIDTH  dividend (rs); sampled at accept.
- opdata2_i  in  WIDTH  divisor (rt); sampled at accept.
- result_o  out  2*WIDTH  {remainder→HI, quotient→LO}; valid only while ready_o=1.
- ready_o  out  1  result valid.
- stall_o  out  1  combinational start_i & ~ready_o, routed to the hazard unit.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; counter=0.
  - result_o=0, ready_o=0.
  - Internal dividend, divisor and sign flags cleared.
- States: IDLE, DIVZERO, ON, END; registered 2-bit encoding.
- IDLE:
  - start_i=1 & annul_i=0 & opdata2_i==0 → DIVZERO.
  - start_i=1 & annul_i=0 & opdata2_i!=0 → ON; latch the operands and signed_i; counter=0.
  - Signed mode latches absolute values plus two sign flags: quotient sign = sign1^sign2, remainder sign = sign1.
  - Otherwise stay in IDLE; ready_o=0.
- ON:
  - One restoring step per cycle. Shift the {partial remainder, dividend} register left by 1, then trial-subtract the divisor from the upper (WIDTH+1)-bit partial remainder.
  - If the trial is non-negative, keep the difference and set quotient bit 1; else restore and set 0.
  - counter increments each step. After step WIDTH (counter==WIDTH-1 on entry) → END.
  - In END, quotient and remainder are sign-corrected (two's-complement negate) when signed and the corresponding flag is set.
- DIVZERO: next cycle → END with result_o = 0 (decided value for MIPS UNPREDICTABLE).
- END:
  - ready_o=1; result_o holds the corrected result.
  - Stay in END while start_i=1 (pipeline may still be stalled downstream).
  - start_i=0 → IDLE; ready_o=0 and result_o=0 on that transition.
- Latency from accept at cycle t:
  - Normal divide: ready_o=1 at t+WIDTH+1 (t+33 for WIDTH=32).
  - Divide by zero: ready_o=1 at t+2.
- Annul: annul_i=1 in any state → IDLE next cycle, ready_o=0, result_o=0, partial work discarded. This takes priority over start_i.
- Back-to-back divides: a new request is accepted only from IDLE. start_i must drop for at least one cycle after ready_o, which the pipeline guarantees as the instruction advances.
- Width/wrap:
  - Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0 (wraps, no trap).
  - The absolute value of 0x80000000 is 0x80000000 treated as unsigned, which is correct for this algorithm.
- Operand changes on opdata*_i after accept are ignored.
- Reset asserted mid-operation → immediate IDLE, outputs 0; no partial result is ever presented.

Decomposition:
- Shared package (cpu_defs):
  - State encodings DIV_IDLE/DIV_ZERO/DIV_ON/DIV_END.
  - The alucontrol codes for DIV/DIVU, so the execute-stage start_i/signed_i decode matches the aludec encoding.
- Optional sub-module div_step: combinational single-iteration shift/trial-subtract on (WIDTH+1) bits, instantiated once.
- The FSM, counter and sign correction stay in div_unit.

Test Plan:
- Reset: rst=0 mid-ON → ready_o=0, result_o=0 immediately; after release, start_i=1, 100/7 unsigned → at t+33 result_o={32'd2, 32'd14}, ready_o=1.
- Signed: -7/2 (0xFFFFFFF9, 2, signed_i=1) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 7/-2 → quotient 0xFFFFFFFD, remainder 1.
- Unsigned large: 0xFFFFFFFF/0x10 unsigned → quotient 0x0FFFFFFF, remainder 0xF; same operands signed → quotient 0, remainder 0xFFFFFFFF.
- Divide by zero: opdata2_i=0 → ready_o=1 at t+2, result_o=0. Overflow: 0x80000000/0xFFFFFFFF signed → {0, 0x80000000}.
- Annul: assert annul_i at t+10 → state IDLE at t+11, ready_o never rises; a new start_i at t+12 with 9/3 → ready at t+45 with {0, 3}.
- Handshake: hold start_i high 5 cycles after ready_o → ready_o and result_o stable, stall_o=0 throughout; drop start_i → ready_o=0 next cycle.
